fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_stage_pc_next_sel.sv | 27 ++
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and types for the fetch stage.
// Holds the reset/exception vectors, the exception bit index and FSM states.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VEC   = 32'hBFC0_0380;
    localparam int unsigned EX_ADEL   = 0;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// pc_next_sel: next-PC priority mux for the fetch stage.
// Exception vector beats ERET, which beats a taken branch, which beats pc+4.
module pc_next_sel
    import fetch_stage_pkg::*;
(
    input  logic        exc_flush,
    input  logic        eret_flush,
    input  logic [31:0] epc,
    input  logic        br_pend,
    input  logic [31:0] br_tgt,
    input  logic [31:0] pc,
    output logic [31:0] pc_next
);

    // Priority select; pc+4 wraps naturally in 32 bits.
    always_comb begin
        pc_next = pc + 32'd4;
        if (exc_flush) begin
            pc_next = EXC_VEC;
        end else if (eret_flush) begin
            pc_next = epc;
        end else if (br_pend) begin
            pc_next = br_tgt;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: one-request-in-flight instruction fetch with delay-slot
// tracking, AdEL detection and flush redirect with stale-data discard.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        next_allow,
    output logic        valid,
    output logic        is_bd,
    output logic [5:0]  ex,
    output logic [31:0] pc,
    output logic [31:0] inst,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_flush,
    input  logic        eret_flush,
    input  logic [31:0] epc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, pc_nxt;
    logic [31:0]  inst_q, inst_d;
    logic [5:0]   ex_q, ex_d;
    logic [31:0]  pend_tgt_q, pend_tgt_d, br_tgt;
    logic         pend_q, pend_d;
    logic         disc_q, disc_d;
    logic         flush, misalign, handoff, take_now, br_pend;

    assign flush     = exc_flush | eret_flush;
    assign misalign  = pc_q[1:0] != 2'b00;
    assign valid     = (state_q == HOLD) & ~flush;
    assign handoff   = valid & next_allow;
    assign take_now  = handoff & br_valid & br_taken;
    assign br_pend   = take_now | pend_q;
    assign br_tgt    = take_now ? br_target : pend_tgt_q;
    assign is_bd     = valid & br_valid;
    assign inst_req  = (state_q == REQ) & ~misalign;
    assign inst_addr = pc_q;
    assign pc        = pc_q;
    assign inst      = inst_q;
    assign ex        = ex_q;

    pc_next_sel u_pc_sel (
        .exc_flush  (exc_flush),
        .eret_flush (eret_flush),
        .epc        (epc),
        .br_pend    (br_pend),
        .br_tgt     (br_tgt),
        .pc         (pc_q),
        .pc_next    (pc_nxt)
    );

    // Next-state, PC redirect, branch-pending and capture logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        ex_d       = ex_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        disc_d     = disc_q;

        if (flush | handoff) begin
            pc_d   = pc_nxt;
            pend_d = 1'b0;
        end else if (valid & br_valid & br_taken) begin
            pend_d     = 1'b1;
            pend_tgt_d = br_target;
        end

        unique case (state_q)
            REQ: begin
                if (misalign) begin
                    if (!flush) begin
                        state_d       = HOLD;
                        inst_d        = '0;
                        ex_d          = '0;
                        ex_d[EX_ADEL] = 1'b1;
                    end
                end else if (inst_addr_ok) begin
                    state_d = WAIT;
                    disc_d  = flush;
                end
            end
            WAIT: begin
                if (inst_data_ok) begin
                    disc_d = 1'b0;
                    if (disc_q | flush) begin
                        state_d = REQ;
                    end else begin
                        state_d = HOLD;
                        inst_d  = inst_rdata;
                        ex_d    = '0;
                    end
                end else if (flush) begin
                    disc_d = 1'b1;
                end
            end
            HOLD: begin
                if (flush | handoff) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= REQ;
            pc_q       <= RESET_VEC;
            inst_q     <= '0;
            ex_q       <= '0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            disc_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            ex_q       <= ex_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            disc_q     <= disc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus random checks of fetch_stage against an
// instruction-stream model and a latency-configurable memory responder.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        next_allow = 1'b0;
    logic        valid, is_bd;
    logic [5:0]  ex;
    logic [31:0] pc, inst;
    logic        br_valid = 1'b0, br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        exc_flush = 1'b0, eret_flush = 1'b0;
    logic [31:0] epc = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;

    int errors = 0;
    int checks = 0;
    int hand = 0;
    logic [31:0] m_pc = RESET_VEC;
    logic [31:0] h_pc, h_inst;
    logic        h_bd;

    int lat_min = 0, lat_max = 0, aok_pct = 100;
    bit force_en = 1'b0;
    logic [31:0] force_val = '0;
    bit m_busy = 1'b0;
    int m_cnt = 0;
    logic [31:0] m_addr = '0;

    fetch_stage dut (
        .clock        (clock),
        .resetn       (resetn),
        .next_allow   (next_allow),
        .valid        (valid),
        .is_bd        (is_bd),
        .ex           (ex),
        .pc           (pc),
        .inst         (inst),
        .br_valid     (br_valid),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .exc_flush    (exc_flush),
        .eret_flush   (eret_flush),
        .epc          (epc),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: one request at a time, data after lat cycles.
    initial begin : mem
        bit fr, fd;
        logic [31:0] fa;
        forever begin
            @(negedge clock);
            fr = inst_req & inst_addr_ok;
            fa = inst_addr;
            fd = inst_data_ok;
            @(posedge clock);
            #1;
            if (!resetn) begin
                m_busy = 1'b0;
            end else begin
                if (fd) m_busy = 1'b0;
                else if (m_busy && m_cnt > 0) m_cnt--;
                if (fr) begin
                    m_busy = 1'b1;
                    m_addr = fa;
                    m_cnt  = int'($urandom_range(lat_max, lat_min));
                end
            end
            inst_data_ok = m_busy && m_cnt == 0;
            if (inst_data_ok) begin
                inst_rdata = force_en ? force_val : memword(m_addr);
                force_en = 1'b0;
            end else begin
                inst_rdata = $urandom;
            end
            inst_addr_ok = !m_busy && ($urandom_range(99, 0) < aok_pct);
        end
    end

    // One clock: check the interface at the negedge, update the model.
    task automatic step();
        @(negedge clock);
        if (resetn) begin
            if (inst_req) begin
                chk("req_addr", inst_addr, m_pc);
                chk("one_outstanding", 32'(m_busy), 32'd0);
            end
            if (exc_flush || eret_flush)
                chk("flush_valid", 32'(valid), 32'd0);
            if (valid && next_allow) begin
                hand++;
                h_pc = pc;
                h_inst = inst;
                h_bd = is_bd;
                chk("hand_pc", pc, m_pc);
                if (m_pc[1:0] != 2'b00) begin
                    chk("hand_inst", inst, 32'd0);
                    chk("hand_ex", 32'(ex), 32'd1);
                end else begin
                    chk("hand_inst", inst, memword(m_pc));
                    chk("hand_ex", 32'(ex), 32'd0);
                end
                chk("hand_bd", 32'(is_bd), 32'(br_valid));
                if (br_valid && br_taken) m_pc = br_target;
                else m_pc = m_pc + 32'd4;
            end
            if (exc_flush) m_pc = EXC_VEC;
            else if (eret_flush) m_pc = epc;
        end
        @(posedge clock);
        #2;
    endtask

    task automatic wait_hand(input string tag, output int cyc);
        int h0;
        h0 = hand;
        cyc = 0;
        while (hand == h0 && cyc < 60) begin
            step();
            cyc++;
        end
        chk({tag, "_timeout"}, 32'(hand != h0), 32'd1);
    endtask

    initial begin : main
        int n, cyc, h0, r;
        logic [31:0] x, p0, i0, rv;

        #1 resetn = 1'b0;
        repeat (3) step();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_bd", 32'(is_bd), 32'd0);
        chk("rst_ex", 32'(ex), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", pc, RESET_VEC);

        resetn = 1'b1;
        next_allow = 1'b1;
        chk("boot_req", 32'(inst_req), 32'd1);
        chk("boot_addr", inst_addr, RESET_VEC);
        wait_hand("first", cyc);
        chk("first_pc", h_pc, 32'hBFC0_0000);
        wait_hand("second", cyc);
        chk("second_pc", h_pc, 32'hBFC0_0004);
        chk("throughput", 32'(cyc), 32'd3);

        next_allow = 1'b0;
        n = 0;
        while (!valid && n < 30) begin step(); n++; end
        chk("hold_reach", 32'(valid), 32'd1);
        p0 = pc;
        i0 = inst;
        chk("hold_pc0", p0, 32'hBFC0_0008);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_valid", 32'(valid), 32'd1);
            chk("hold_pc", pc, p0);
            chk("hold_inst", inst, i0);
        end
        h0 = hand;
        next_allow = 1'b1;
        step();
        next_allow = 1'b0;
        repeat (6) step();
        chk("release_once", 32'(hand - h0), 32'd1);

        next_allow = 1'b1;
        wait_hand("br_x", cyc);
        x = h_pc;
        br_valid = 1'b1;
        br_taken = 1'b1;
        br_target = 32'h8000_1000;
        wait_hand("br_ds", cyc);
        chk("ds_pc", h_pc, x + 32'd4);
        chk("ds_bd", 32'(h_bd), 32'd1);
        br_valid = 1'b0;
        br_taken = 1'b0;
        wait_hand("br_tgt", cyc);
        chk("tgt_pc", h_pc, 32'h8000_1000);
        chk("tgt_bd", 32'(h_bd), 32'd0);

        lat_min = 2;
        lat_max = 2;
        n = 0;
        while (!(m_busy && !inst_data_ok) && n < 30) begin step(); n++; end
        chk("wait_reach", 32'(m_busy), 32'd1);
        force_val = 32'hDEAD_BEEF;
        force_en = 1'b1;
        exc_flush = 1'b1;
        step();
        exc_flush = 1'b0;
        n = 0;
        while (!inst_req && n < 30) begin step(); n++; end
        chk("exc_req_addr", inst_addr, EXC_VEC);
        wait_hand("exc", cyc);
        chk("exc_pc", h_pc, EXC_VEC);
        chk("exc_inst", h_inst, memword(EXC_VEC));

        lat_min = 0;
        lat_max = 0;
        n = 0;
        while (!inst_data_ok && n < 30) begin step(); n++; end
        chk("dok_reach", 32'(inst_data_ok), 32'd1);
        eret_flush = 1'b1;
        epc = 32'h8000_0100;
        step();
        eret_flush = 1'b0;
        chk("dok_flush_req", 32'(inst_req), 32'd1);
        chk("dok_flush_addr", inst_addr, 32'h8000_0100);
        wait_hand("eret", cyc);
        chk("eret_pc", h_pc, 32'h8000_0100);

        next_allow = 1'b0;
        n = 0;
        while (!valid && n < 30) begin step(); n++; end
        eret_flush = 1'b1;
        epc = 32'h8000_0002;
        step();
        eret_flush = 1'b0;
        n = 0;
        while (!valid && n < 10) begin
            chk("adel_noreq", 32'(inst_req), 32'd0);
            step();
            n++;
        end
        chk("adel_valid", 32'(valid), 32'd1);
        chk("adel_pc", pc, 32'h8000_0002);
        chk("adel_ex", 32'(ex), 32'd1);
        chk("adel_inst", inst, 32'd0);
        next_allow = 1'b1;
        wait_hand("adel", cyc);

        exc_flush = 1'b1;
        eret_flush = 1'b1;
        epc = 32'h8000_0040;
        step();
        exc_flush = 1'b0;
        eret_flush = 1'b0;
        chk("both_req", 32'(inst_req), 32'd1);
        chk("both_addr", inst_addr, EXC_VEC);
        wait_hand("both", cyc);
        chk("both_pc", h_pc, EXC_VEC);

        lat_min = 0;
        lat_max = 3;
        aok_pct = 60;
        h0 = hand;
        for (int i = 0; i < 600; i++) begin
            int hb;
            next_allow = ($urandom_range(99, 0) < 70);
            exc_flush = 1'b0;
            eret_flush = 1'b0;
            r = int'($urandom_range(99, 0));
            rv = $urandom;
            if (r < 3) begin
                exc_flush = 1'b1;
                br_valid = 1'b0;
            end else if (r < 6) begin
                eret_flush = 1'b1;
                epc = {16'h8000, rv[15:2],
                       (rv[31:30] == 2'b00) ? rv[1:0] : 2'b00};
                br_valid = 1'b0;
            end else if (!br_valid && r < 18) begin
                br_valid = 1'b1;
                br_taken = rv[31];
                br_target = {16'h8000, rv[15:2], 2'b00};
            end
            hb = hand;
            step();
            if (hand != hb) br_valid = 1'b0;
        end
        exc_flush = 1'b0;
        eret_flush = 1'b0;
        br_valid = 1'b0;
        chk("rand_progress", 32'(hand - h0 > 20), 32'd1);

        lat_min = 3;
        lat_max = 3;
        aok_pct = 100;
        next_allow = 1'b1;
        n = 0;
        while (!(m_busy && !inst_data_ok) && n < 40) begin step(); n++; end
        chk("mid_busy", 32'(m_busy), 32'd1);
        resetn = 1'b0;
        step();
        step();
        chk("mid_valid", 32'(valid), 32'd0);
        chk("mid_pc", pc, RESET_VEC);
        chk("mid_ex", 32'(ex), 32'd0);
        m_pc = RESET_VEC;
        lat_min = 0;
        lat_max = 0;
        resetn = 1'b1;
        chk("mid_req", 32'(inst_req), 32'd1);
        chk("mid_addr", inst_addr, RESET_VEC);
        wait_hand("mid", cyc);
        chk("mid_hand_pc", h_pc, RESET_VEC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
